pulse_event_scheduler: RTL and testbench
========================================

# pulse_event_scheduler

Collects single-cycle event pulses from up to `EVENT_COUNT` sources into per-source pulse latches and serves them one at a time, in round-robin order, over a valid/ready handshake. It sits between asynchronous-in-time event producers (interrupt-like strobes, completion pulses) and a single FSM consumer, replacing a bank of hand-wired pulse latches with one sequenced resource. It also reports pulses that arrive while their source is already pending.

## Interface
- `EVENT_COUNT`, 4, number of event sources (≥2).
- `INDEX_WIDTH`, 2, width of `event_index`; must equal clog2(`EVENT_COUNT`).
- `OVERRUN_WIDTH`, 8, width of `overrun_count` (used only with the configuration macro).

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pulse_in` in `EVENT_COUNT`: bit i high for one or more cycles = event(s) on source i.
- `mask` in `EVENT_COUNT`: bit i high = source i ineligible for grant; still latches.
- `event_valid` out 1: an event is offered.
- `event_index` out `INDEX_WIDTH`: source of offered event.
- `event_ready` in 1: consumer accepts offered event.
- `pending` out `EVENT_COUNT`: current latch contents.
- `overrun` out `EVENT_COUNT`: sticky per-source flag, a pulse hit an already-pending source.
- `overrun_clear` in 1: synchronous clear of `overrun` (and `overrun_count`).
- `overrun_count` out `OVERRUN_WIDTH`: total overruns, saturating.

## Operation
- Latch i: set when `pulse_in[i]` high; cleared when event i is accepted (`event_valid & event_ready`, `event_index`==i). Same-cycle set and clear: set wins, latch stays 1 (new event arrived during service; it will be served again).
- Overrun on source i: `pulse_in[i]` high while `pending[i]`==1 and latch i not being cleared this cycle. Sets `overrun[i]`; increments `overrun_count` by number of sources overrunning that cycle, saturating at all-ones. `overrun_clear` wins over same-cycle overrun set.
- FSM, two states:
  - IDLE: `event_valid`=0. If any `pending & ~mask` bit set, pick first eligible index scanning upward from `rr_pointer`, wrapping at `EVENT_COUNT`-1 → 0; register it into `event_index`; go OFFER.
  - OFFER: `event_valid`=1; `event_index` stable. On `event_ready`: clear latch (rule above), `rr_pointer` ← index+1 mod `EVENT_COUNT`, go IDLE. Changing `mask` during OFFER does not withdraw the offer.
- `event_ready` outside OFFER is ignored.
- Reset: all latches, `overrun`, `overrun_count`, `rr_pointer`, `event_index` = 0; state IDLE; `event_valid` = 0, asynchronously, including mid-OFFER (offered event discarded).

## Timing
- Pulse at cycle N → `pending[i]`=1 visible at N+1 → `event_valid`=1 at N+2 (if FSM idle and source eligible).
- Accept at cycle M → `pending[i]`=0 and `event_valid`=0 at M+1; next offer earliest M+2. Max throughput one event per 2 cycles.
- All outputs registered; no combinational path input → output.
- `overrun`/`overrun_count` update one cycle after the causing pulse.

## Configuration
- `PULSE_EVENT_SCHEDULER_OVERRUN_COUNT_EN` defined: `overrun_count` counter implemented as above.
- Not defined: no counter logic; `overrun_count` tied to 0. Per-source `overrun` flags present in both builds.

## Test plan
- Reset, single pulse on source 2 at cycle 5, `event_ready` held 1 → `event_valid`=1, `event_index`=2 at cycle 7; `pending`=0 at cycle 8.
- Pulses on sources 0,1,3 same cycle, `event_ready`=1 → served order 0,1,3, each offer 2 cycles apart; then pulse on 0 and 3 with `rr_pointer`=0 after 3 → 0 then 3.
- Source 1 offered, `event_ready`=0 for 5 cycles, pulse on 1 at cycle 3 → `overrun[1]`=1, count=1; index stays 1; after accept latch cleared.
- Pulse on source 1 in the same cycle its offer is accepted → `pending[1]` stays 1, no overrun, source 1 re-offered 2 cycles later.
- `mask`=4'b0001, pulses on 0 and 2 → only 2 served; drop mask → 0 served next.
- Assert `reset` mid-OFFER → `event_valid`, `pending`, `overrun`, `overrun_count` = 0 immediately; with macro undefined `overrun_count` = 0 throughout.

Source files
------------

// File: rtl/pulse_event_scheduler.sv
// pulse_event_scheduler
//
// Purpose:
//   Latches single-cycle event pulses from EVENT_COUNT sources and serves them one
//   at a time, round-robin, over a valid/ready handshake. Pulses that land on an
//   already-pending source are flagged as overruns.
//
// Configuration macro:
//   PULSE_EVENT_SCHEDULER_OVERRUN_COUNT_EN - when defined, overrun_count is a
//   saturating counter of overruns; otherwise overrun_count is tied to 0.
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous active-high reset
//   pulse_in       in   per-source event pulses
//   mask           in   per-source grant inhibit (latching unaffected)
//   event_valid    out  an event is offered
//   event_index    out  source of the offered event
//   event_ready    in   consumer accepts the offered event
//   pending        out  per-source latch contents
//   overrun        out  sticky per-source overrun flags
//   overrun_clear  in   synchronous clear of overrun and overrun_count
//   overrun_count  out  saturating total overrun count

module pulse_event_scheduler #(
    parameter int unsigned EVENT_COUNT   = 4,
    parameter int unsigned INDEX_WIDTH   = 2,
    parameter int unsigned OVERRUN_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [EVENT_COUNT-1:0]   pulse_in,
    input  logic [EVENT_COUNT-1:0]   mask,
    output logic                     event_valid,
    output logic [INDEX_WIDTH-1:0]   event_index,
    input  logic                     event_ready,
    output logic [EVENT_COUNT-1:0]   pending,
    output logic [EVENT_COUNT-1:0]   overrun,
    input  logic                     overrun_clear,
    output logic [OVERRUN_WIDTH-1:0] overrun_count
);

    typedef enum logic {StIdle, StOffer} state_e;

    state_e                 state;
    logic [INDEX_WIDTH-1:0] rr_pointer;
    logic [INDEX_WIDTH-1:0] next_rr;
    logic [INDEX_WIDTH-1:0] pick;
    logic                   any_eligible;
    logic [EVENT_COUNT-1:0] eligible;
    logic [EVENT_COUNT-1:0] accept_vec;
    logic [EVENT_COUNT-1:0] hit;

    assign eligible = pending & ~mask;

    // One-hot of the latch being cleared by an accepted offer this cycle.
    always_comb begin
        accept_vec = '0;
        if (state == StOffer && event_ready) begin
            accept_vec[event_index] = 1'b1;
        end
    end

    // A pulse on a latch that is being cleared is a fresh event, not an overrun.
    assign hit = pulse_in & pending & ~accept_vec;

    // First eligible source at or after rr_pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        pick         = '0;
        any_eligible = 1'b0;
        for (int unsigned k = 0; k < EVENT_COUNT; k++) begin
            idx = (32'(rr_pointer) + k) % EVENT_COUNT;
            if (!any_eligible && eligible[idx]) begin
                pick         = INDEX_WIDTH'(idx);
                any_eligible = 1'b1;
            end
        end
    end

    assign next_rr = (event_index == INDEX_WIDTH'(EVENT_COUNT - 1)) ? '0
                                                                    : event_index + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            event_valid <= 1'b0;
            event_index <= '0;
            rr_pointer  <= '0;
            pending     <= '0;
            overrun     <= '0;
        end else begin
            // Set wins over a same-cycle clear.
            pending <= (pending & ~accept_vec) | pulse_in;
            overrun <= overrun_clear ? '0 : (overrun | hit);
            case (state)
                StIdle: begin
                    if (any_eligible) begin
                        event_index <= pick;
                        event_valid <= 1'b1;
                        state       <= StOffer;
                    end
                end
                StOffer: begin
                    // Offer is held regardless of mask changes until accepted.
                    if (event_ready) begin
                        rr_pointer  <= next_rr;
                        event_valid <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: begin
                    event_valid <= 1'b0;
                    state       <= StIdle;
                end
            endcase
        end
    end

`ifdef PULSE_EVENT_SCHEDULER_OVERRUN_COUNT_EN
    int unsigned            hit_count;
    logic [OVERRUN_WIDTH:0] count_sum;

    always_comb begin
        hit_count = 0;
        for (int unsigned i = 0; i < EVENT_COUNT; i++) begin
            hit_count = hit_count + 32'(hit[i]);
        end
        count_sum = {1'b0, overrun_count} + (OVERRUN_WIDTH + 1)'(hit_count);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_count <= '0;
        end else if (overrun_clear) begin
            overrun_count <= '0;
        end else if (count_sum[OVERRUN_WIDTH]) begin
            overrun_count <= '1;
        end else begin
            overrun_count <= count_sum[OVERRUN_WIDTH-1:0];
        end
    end
`else
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_pulse_event_scheduler.sv
// Scoreboard bench for pulse_event_scheduler: the stimulus pushes the expected
// (index, accept cycle) of every offer; a negedge monitor pops and compares on
// each accepted handshake. Latch/overrun state is checked directly.

module tb_pulse_event_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pulse_in = '0;
    logic [3:0] mask = '0;
    logic       event_ready = 1'b0;
    logic       overrun_clear = 1'b0;
    logic       event_valid;
    logic [1:0] event_index;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic [7:0] overrun_count;

`ifdef PULSE_EVENT_SCHEDULER_OVERRUN_COUNT_EN
    localparam logic [7:0] OVR1 = 8'd1;
`else
    localparam logic [7:0] OVR1 = 8'd0;
`endif

    typedef struct {
        logic [1:0] idx;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n;
    int   m;

    pulse_event_scheduler #(
        .EVENT_COUNT  (4),
        .INDEX_WIDTH  (2),
        .OVERRUN_WIDTH(8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pulse_in     (pulse_in),
        .mask         (mask),
        .event_valid  (event_valid),
        .event_index  (event_index),
        .event_ready  (event_ready),
        .pending      (pending),
        .overrun      (overrun),
        .overrun_clear(overrun_clear),
        .overrun_count(overrun_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int k);
        repeat (k) tick();
    endtask

    task automatic push(input logic [1:0] idx, input int c);
        exp_t x;
        x.idx = idx;
        x.cyc = c;
        exp_q.push_back(x);
    endtask

    task automatic pulse(input logic [3:0] p);
        pulse_in = p;
        tick();
        pulse_in = '0;
    endtask

    // Monitor: every accepted handshake must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (event_valid && event_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_accept: got index %0d at cycle %0d, required none",
                             event_index, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("accept_index", 32'(event_index), 32'(e.idx));
                    check("accept_cycle", cyc, e.cyc);
                end
            end
`ifndef PULSE_EVENT_SCHEDULER_OVERRUN_COUNT_EN
            check("count_tied_zero", 32'(overrun_count), 32'd0);
`endif
        end
    end

    initial begin
        // Reset state
        ticks(2);
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_index", 32'(event_index), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_count", 32'(overrun_count), 32'd0);
        reset = 1'b0;
        ticks(2);

        // Single pulse on source 2, ready held high
        event_ready = 1'b1;
        n = cyc;
        push(2'd2, n + 2);
        pulse(4'b0100);
        check("t1_pending_set", 32'(pending), 32'b0100);
        tick();
        check("t1_offer_valid", 32'(event_valid), 32'd1);
        check("t1_offer_index", 32'(event_index), 32'd2);
        tick();
        check("t1_pending_clr", 32'(pending), 32'd0);
        check("t1_valid_drop", 32'(event_valid), 32'd0);
        ticks(2);

        // Round robin 0,1,3 from rr_pointer 0, then 0,3 after wrap
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n = cyc;
        push(2'd0, n + 2);
        push(2'd1, n + 4);
        push(2'd3, n + 6);
        pulse(4'b1011);
        ticks(7);
        check("t2_pending_clr", 32'(pending), 32'd0);
        n = cyc;
        push(2'd0, n + 2);
        push(2'd3, n + 4);
        pulse(4'b1001);
        ticks(5);

        // Overrun while offered and held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        event_ready = 1'b0;
        tick();
        n = cyc;
        pulse(4'b0010);
        tick();
        check("t3_offer_valid", 32'(event_valid), 32'd1);
        check("t3_offer_index", 32'(event_index), 32'd1);
        tick();
        pulse(4'b0010);
        check("t3_overrun", 32'(overrun), 32'b0010);
        check("t3_count", 32'(overrun_count), 32'(OVR1));
        check("t3_index_held", 32'(event_index), 32'd1);
        check("t3_valid_held", 32'(event_valid), 32'd1);
        ticks(3);
        event_ready = 1'b1;
        push(2'd1, n + 7);
        tick();
        check("t3_pending_clr", 32'(pending), 32'd0);
        check("t3_overrun_sticky", 32'(overrun), 32'b0010);
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        check("t3_overrun_clr", 32'(overrun), 32'd0);
        check("t3_count_clr", 32'(overrun_count), 32'd0);

        // Pulse in the same cycle as accept: re-latched, no overrun, re-offered
        n = cyc;
        push(2'd1, n + 2);
        push(2'd1, n + 4);
        pulse(4'b0010);
        tick();
        pulse(4'b0010);
        check("t4_pending_kept", 32'(pending), 32'b0010);
        check("t4_no_overrun", 32'(overrun), 32'd0);
        check("t4_valid_gap", 32'(event_valid), 32'd0);
        ticks(3);

        // Masked source latches but is not served until unmasked
        mask = 4'b0001;
        n = cyc;
        push(2'd2, n + 2);
        pulse(4'b0101);
        ticks(4);
        check("t5_masked_pending", 32'(pending), 32'b0001);
        check("t5_masked_idle", 32'(event_valid), 32'd0);
        m = cyc;
        mask = 4'b0000;
        push(2'd0, m + 1);
        ticks(3);
        check("t5_pending_clr", 32'(pending), 32'd0);

        // Reset asserted mid-offer
        event_ready = 1'b0;
        pulse(4'b1000);
        tick();
        pulse(4'b1000);
        check("t6_overrun", 32'(overrun), 32'b1000);
        check("t6_count", 32'(overrun_count), 32'(OVR1));
        tick();
        check("t6_offer_valid", 32'(event_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(event_valid), 32'd0);
        check("t6_rst_pending", 32'(pending), 32'd0);
        check("t6_rst_overrun", 32'(overrun), 32'd0);
        check("t6_rst_count", 32'(overrun_count), 32'd0);
        tick();
        reset = 1'b0;
        ticks(3);
        check("t6_no_offer", 32'(event_valid), 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
